// File: rtl/riscv_defs_pkg.sv
// rtl/riscv_defs_pkg.sv - shared RV32I pipeline encodings
//
// Purpose: encodings shared by every pipeline stage. These are the
//          write-back result source select and the load funct3 codes.
// Ports:   none (package).
package riscv_defs_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } result_src_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load data byte/halfword extraction and extension
//
// Purpose: selects the addressed byte, halfword or word from the raw memory
//          word and sign- or zero-extends it.
//          Illegal funct3 codes flag err and return zero data.
// Ports:   funct3 in  3  load size/sign encoding
//          off    in  2  byte offset within the word
//          word   in 32  raw aligned memory word
//          data   out 32 extended load data
//          err    out 1  funct3 is not a legal load encoding
module load_extend
   import riscv_defs_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] data,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (off)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      // Halfword loads ignore off[0].
      half_sel = off[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         F3_LW:   data = word;
         default: err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I MEM/WB pipeline register and write-back
//
// Purpose: MEM/WB pipeline register, load extraction, write-back mux,
//          register file write port, optional W-to-D bypass and a
//          retired-instruction counter.
//          Optional feature macro: WB_BYPASS_EN. When it is defined, decode
//          operands are forwarded from the write-back value.
// Ports:   clk, rst (sync, active-high); stall_W, flush_W
//          M inputs: valid_M, RegWrite_M, ResultSrc_M, funct3_M, ALUResult_M,
//                    ReadData_M, PCPlus4_M, Rd_M
//          decode: A1_D, A2_D, RD1_rf, RD2_rf -> RD1_D, RD2_D
//          write port: WE_reg, A3, WD_reg
//          status: valid_W, load_err, instret
module mem_wb_stage
   import riscv_defs_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_W,
   input  logic            flush_W,
   input  logic            valid_M,
   input  logic            RegWrite_M,
   input  logic [1:0]      ResultSrc_M,
   input  logic [2:0]      funct3_M,
   input  logic [XLEN-1:0] ALUResult_M,
   input  logic [XLEN-1:0] ReadData_M,
   input  logic [XLEN-1:0] PCPlus4_M,
   input  logic [4:0]      Rd_M,
   input  logic [4:0]      A1_D,
   input  logic [4:0]      A2_D,
   input  logic [XLEN-1:0] RD1_rf,
   input  logic [XLEN-1:0] RD2_rf,
   output logic            WE_reg,
   output logic [4:0]      A3,
   output logic [XLEN-1:0] WD_reg,
   output logic            valid_W,
   output logic            load_err,
   output logic [XLEN-1:0] RD1_D,
   output logic [XLEN-1:0] RD2_D,
   output logic [63:0]     instret
);

   logic            RegWrite_W;
   logic [1:0]      ResultSrc_W;
   logic [2:0]      funct3_W;
   logic [XLEN-1:0] ALUResult_W;
   logic [XLEN-1:0] ReadData_W;
   logic [XLEN-1:0] PCPlus4_W;
   logic [4:0]      Rd_W;
   logic [XLEN-1:0] load_data;
   logic            ext_err;

   // Flush only kills valid; the other fields are don't-care once invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_W     <= 1'b0;
         RegWrite_W  <= 1'b0;
         ResultSrc_W <= 2'b00;
         funct3_W    <= 3'b000;
         ALUResult_W <= '0;
         ReadData_W  <= '0;
         PCPlus4_W   <= '0;
         Rd_W        <= 5'd0;
      end else if (flush_W) begin
         valid_W <= 1'b0;
      end else if (!stall_W) begin
         valid_W     <= valid_M;
         RegWrite_W  <= RegWrite_M;
         ResultSrc_W <= ResultSrc_M;
         funct3_W    <= funct3_M;
         ALUResult_W <= ALUResult_M;
         ReadData_W  <= ReadData_M;
         PCPlus4_W   <= PCPlus4_M;
         Rd_W        <= Rd_M;
      end
   end

   // The W instruction retires at the first unstalled edge. A flush at that
   // edge only replaces what follows it, so the instruction is still counted.
   always_ff @(posedge clk) begin
      if (rst)
         instret <= 64'd0;
      else if (valid_W && !stall_W)
         instret <= instret + 64'd1;
   end

   load_extend u_load_extend (
      .funct3 (funct3_W),
      .off    (ALUResult_W[1:0]),
      .word   (ReadData_W),
      .data   (load_data),
      .err    (ext_err)
   );

   assign load_err = valid_W && (ResultSrc_W == RES_LOAD) && ext_err;

   always_comb begin
      WD_reg = '0;
      case (ResultSrc_W)
         RES_ALU:  WD_reg = ALUResult_W;
         RES_LOAD: WD_reg = load_data;
         RES_PC4:  WD_reg = PCPlus4_W;
         default:  WD_reg = '0;
      endcase
   end

   assign A3     = Rd_W;
   assign WE_reg = valid_W && RegWrite_W && (Rd_W != 5'd0) && !load_err;

`ifdef WB_BYPASS_EN
   // WE_reg already excludes x0, so x0 reads are never forwarded.
   assign RD1_D = (WE_reg && (A1_D == A3)) ? WD_reg : RD1_rf;
   assign RD2_D = (WE_reg && (A2_D == A3)) ? WD_reg : RD2_rf;
`else
   wire unused_bypass = ^{A1_D, A2_D};
   assign RD1_D = RD1_rf;
   assign RD2_D = RD2_rf;
`endif

endmodule
